// File: rtl/bram_heap_pq.sv
// Binary-heap priority queue of key/payload pairs in inferred dual-read BRAM.
// Latency: up to 2*ceil(log2(QUEUE_SIZE+1))+3 cycles per operation (2 per heap level).
// Backpressure: o_ready low while an operation runs; requests seen then are ignored.
module bram_heap_pq #(
  parameter int QUEUE_SIZE    = 7,
  parameter int DATA_WIDTH    = 16,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int MIN_MODE      = 0
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            i_wrt,
  input  logic                            i_read,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic [PAYLOAD_WIDTH-1:0]        i_payload,
  output logic                            o_ready,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [PAYLOAD_WIDTH-1:0]        o_payload,
  output logic                            o_err
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int XW = CW + 1;
  localparam int EW = DATA_WIDTH + PAYLOAD_WIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_UP_RD   = 3'd1;
  localparam logic [2:0] S_UP_CMP  = 3'd2;
  localparam logic [2:0] S_LAST_RD = 3'd3;
  localparam logic [2:0] S_DN_RD   = 3'd4;
  localparam logic [2:0] S_DN_CMP  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // Strict comparison: equal keys never beat each other, so ties never swap.
  function automatic logic f_beats(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return (MIN_MODE != 0) ? (a < b) : (a > b);
  endfunction

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_idx;
  logic [EW-1:0] r_mov;
  logic [EW-1:0] r_out;
  logic          r_err;
  logic          r_done_wait;

  logic [EW-1:0] r_mem [0:QUEUE_SIZE-1];
  logic [EW-1:0] r_rd_a;
  logic [EW-1:0] r_rd_b;

  logic          w_idle, w_full, w_empty;
  logic          w_do_enq, w_do_deq, w_do_rep, w_bad;
  logic [XW-1:0] w_lc, w_rc, w_cnt_x;
  logic          w_has_kids, w_has_right;
  logic          w_right_wins, w_best_beats, w_mov_beats_par;
  logic [EW-1:0] w_best;
  logic [CW-1:0] w_best_idx;
  logic [CW-1:0] w_ra, w_rb, w_wa;
  logic          w_we;
  logic [EW-1:0] w_wd;

  assign w_idle  = (r_state == S_IDLE);
  assign w_full  = (r_cnt == CW'(QUEUE_SIZE));
  assign w_empty = (r_cnt == '0);

  // Replace on an empty heap degenerates to a plain insert.
  assign w_do_enq = w_idle & i_wrt & (i_read ? w_empty : ~w_full);
  assign w_do_deq = w_idle & i_read & ~i_wrt & ~w_empty;
  assign w_do_rep = w_idle & i_read & i_wrt & ~w_empty;
  assign w_bad    = w_idle & ((i_wrt & ~i_read & w_full) | (i_read & ~i_wrt & w_empty));

  // Child indices are one bit wider so 2*idx+1 never wraps before the bound test.
  assign w_lc        = {r_idx, 1'b0};
  assign w_rc        = {r_idx, 1'b1};
  assign w_cnt_x     = {1'b0, r_cnt};
  assign w_has_kids  = (w_lc <= w_cnt_x);
  assign w_has_right = (w_rc <= w_cnt_x);

  assign w_right_wins    = w_has_right & f_beats(r_rd_b[EW-1:PAYLOAD_WIDTH], r_rd_a[EW-1:PAYLOAD_WIDTH]);
  assign w_best          = w_right_wins ? r_rd_b : r_rd_a;
  assign w_best_idx      = w_right_wins ? w_rc[CW-1:0] : w_lc[CW-1:0];
  assign w_best_beats    = f_beats(w_best[EW-1:PAYLOAD_WIDTH], r_mov[EW-1:PAYLOAD_WIDTH]);
  assign w_mov_beats_par = f_beats(r_mov[EW-1:PAYLOAD_WIDTH], r_rd_a[EW-1:PAYLOAD_WIDTH]);

  // RAM port steering; idle read addresses park on node 1 so they stay in range.
  always_comb begin
    w_ra = CW'(1);
    w_rb = CW'(1);
    w_we = 1'b0;
    w_wa = r_idx;
    w_wd = r_mov;
    case (r_state)
      S_IDLE:   if (w_do_deq) w_ra = r_cnt;
      S_UP_RD:  if (r_idx == CW'(1)) w_we = 1'b1; else w_ra = r_idx >> 1;
      S_UP_CMP: begin
        w_we = 1'b1;
        if (w_mov_beats_par) w_wd = r_rd_a;
      end
      S_DN_RD: begin
        if (w_has_kids) begin
          w_ra = w_lc[CW-1:0];
          w_rb = w_has_right ? w_rc[CW-1:0] : w_lc[CW-1:0];
        end else begin
          w_we = 1'b1;
        end
      end
      S_DN_CMP: begin
        w_we = 1'b1;
        if (w_best_beats) w_wd = w_best;
      end
      default: ;
    endcase
  end

  // Heap storage: one write port, two registered read ports, contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_wa - CW'(1)] <= w_wd;
    r_rd_a <= r_mem[w_ra - CW'(1)];
    r_rd_b <= r_mem[w_rb - CW'(1)];
  end

  // Operation sequencer: sift-up for insert, sift-down for remove/replace.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= CW'(1);
      r_mov       <= '0;
      r_out       <= '0;
      r_err       <= 1'b0;
      r_done_wait <= 1'b0;
    end else begin
      r_err <= w_bad;
      case (r_state)
        S_IDLE: begin
          if (w_do_enq) begin
            r_mov   <= {i_data, i_payload};
            r_cnt   <= r_cnt + CW'(1);
            r_idx   <= r_cnt + CW'(1);
            r_state <= S_UP_RD;
          end else if (w_do_deq) begin
            r_cnt   <= r_cnt - CW'(1);
            r_state <= S_LAST_RD;
          end else if (w_do_rep) begin
            r_mov   <= {i_data, i_payload};
            r_idx   <= CW'(1);
            r_state <= S_DN_RD;
          end
        end
        S_UP_RD:  r_state <= (r_idx == CW'(1)) ? S_DONE : S_UP_CMP;
        S_UP_CMP: begin
          if (w_mov_beats_par) begin
            r_idx   <= r_idx >> 1;
            r_state <= S_UP_RD;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_LAST_RD: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_mov   <= r_rd_a;
            r_idx   <= CW'(1);
            r_state <= S_DN_RD;
          end
        end
        S_DN_RD:  r_state <= w_has_kids ? S_DN_CMP : S_DONE;
        S_DN_CMP: begin
          if (w_best_beats) begin
            r_idx   <= w_best_idx;
            r_state <= S_DN_RD;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // First cycle issues the root read; second cycle captures the registered data.
          if (!r_done_wait) begin
            r_done_wait <= 1'b1;
          end else begin
            r_done_wait <= 1'b0;
            r_out       <= (r_cnt == '0) ? '0 : r_rd_a;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = w_idle;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_cnt;
  assign o_data    = r_out[EW-1:PAYLOAD_WIDTH];
  assign o_payload = r_out[PAYLOAD_WIDTH-1:0];
  assign o_err     = r_err;

endmodule

// File: tb/tb_bram_heap_pq.sv
// Bench for bram_heap_pq: a max-heap and a min-heap instance against a queue-based model.
// Each operation waits for o_ready, so latency is measured from the sampling edge.
// Requests are steered to one instance at a time through sel.
module tb_bram_heap_pq;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        wrt, rd, sel;
  logic [15:0] din;
  logic [7:0]  pin;

  logic        rdy0, full0, empty0, err0, rdy1, full1, empty1, err1;
  logic [2:0]  cnt0, cnt1;
  logic [15:0] dat0, dat1;
  logic [7:0]  pl0, pl1;

  logic        rdy, full, empty, err;
  logic [2:0]  cnt;
  logic [15:0] dat;
  logic [7:0]  pl;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: unordered bag of entries; the best key is found by scanning.
  logic [15:0] mk[$];
  logic [7:0]  mp[$];

  int   ob_lat, ob_cnt;
  logic ob_err, ob_rdy;
  logic [15:0] ob_busy_dat;

  always #5 CLK = ~CLK;

  bram_heap_pq #(.QUEUE_SIZE(7), .DATA_WIDTH(16), .PAYLOAD_WIDTH(8), .MIN_MODE(0)) u_max (
    .CLK(CLK), .RSTn(RSTn), .i_wrt(wrt & ~sel), .i_read(rd & ~sel), .i_data(din), .i_payload(pin),
    .o_ready(rdy0), .o_full(full0), .o_empty(empty0), .o_count(cnt0), .o_data(dat0),
    .o_payload(pl0), .o_err(err0));

  bram_heap_pq #(.QUEUE_SIZE(7), .DATA_WIDTH(16), .PAYLOAD_WIDTH(8), .MIN_MODE(1)) u_min (
    .CLK(CLK), .RSTn(RSTn), .i_wrt(wrt & sel), .i_read(rd & sel), .i_data(din), .i_payload(pin),
    .o_ready(rdy1), .o_full(full1), .o_empty(empty1), .o_count(cnt1), .o_data(dat1),
    .o_payload(pl1), .o_err(err1));

  assign rdy   = sel ? rdy1 : rdy0;
  assign full  = sel ? full1 : full0;
  assign empty = sel ? empty1 : empty0;
  assign err   = sel ? err1 : err0;
  assign cnt   = sel ? cnt1 : cnt0;
  assign dat   = sel ? dat1 : dat0;
  assign pl    = sel ? pl1 : pl0;

  function automatic logic [15:0] m_best();
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < mk.size(); i++)
      if (i == 0 || (sel ? (mk[i] < b) : (mk[i] > b))) b = mk[i];
    return b;
  endfunction

  function automatic bit m_has(input logic [15:0] k, input logic [7:0] p);
    for (int i = 0; i < mk.size(); i++)
      if (mk[i] == k && mp[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  // Which of several equal best keys leaves is unspecified; follow the one the root showed.
  function automatic void m_remove_root(input logic [7:0] shown_pl);
    logic [15:0] b;
    int idx;
    b = m_best();
    idx = -1;
    for (int i = 0; i < mk.size(); i++)
      if (idx < 0 && mk[i] == b && mp[i] == shown_pl) idx = i;
    for (int i = 0; i < mk.size(); i++)
      if (idx < 0 && mk[i] == b) idx = i;
    if (idx >= 0) begin
      mk.delete(idx);
      mp.delete(idx);
    end
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0; wrt = 1'b0; rd = 1'b0; din = '0; pin = '0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    mk.delete();
    mp.delete();
  endtask

  // Drives one request for one cycle, records first-cycle observations, waits for ready.
  task automatic run_op(input bit w, input bit r, input logic [15:0] k, input logic [7:0] p);
    logic [7:0] shown;
    bit was_full, was_empty;
    shown = pl;
    was_full = (mk.size() == 7);
    was_empty = (mk.size() == 0);
    @(negedge CLK);
    wrt = w; rd = r; din = k; pin = p;
    @(negedge CLK);
    wrt = 1'b0; rd = 1'b0;
    ob_err = err; ob_rdy = rdy; ob_cnt = int'(cnt); ob_busy_dat = dat;
    ob_lat = 1;
    while (!rdy && ob_lat < 30) begin
      @(negedge CLK);
      ob_lat++;
    end
    if (w && !r) begin
      if (!was_full) begin mk.push_back(k); mp.push_back(p); end
    end else if (r && !w) begin
      if (!was_empty) m_remove_root(shown);
    end else if (w && r) begin
      if (!was_empty) m_remove_root(shown);
      mk.push_back(k); mp.push_back(p);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_checks++;
      if ({rdy, empty, full, err} !== 4'b1100) begin
        n_fail++; $display("FAIL reset_flags dut%0d: rdy/empty/full/err=%b want 1100", s, {rdy, empty, full, err});
      end
      n_checks++;
      if (cnt !== 3'd0 || dat !== 16'd0 || pl !== 8'd0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d: cnt=%0d data=%0d pl=%0d want 0/0/0", s, cnt, dat, pl);
      end
    end
    sel = 1'b0;
    run_op(1'b0, 1'b1, 16'd0, 8'd0);
    n_checks++;
    if (ob_err !== 1'b1 || ob_lat != 1) begin
      n_fail++; $display("FAIL deq_empty_err: err=%b lat=%0d want err=1 lat=1", ob_err, ob_lat);
    end
    n_checks++;
    if (cnt !== 3'd0 || empty !== 1'b1 || dat !== 16'd0) begin
      n_fail++; $display("FAIL deq_empty_state: cnt=%0d empty=%b data=%0d want 0/1/0", cnt, empty, dat);
    end
    @(negedge CLK);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle: err=%b want 0", err);
    end
  endtask

  task automatic test_fill_drain();
    logic [15:0] keys [7];
    logic [15:0] exp_k [7];
    logic [7:0]  exp_p [7];
    keys  = '{16'd5, 16'd900, 16'd12, 16'd900, 16'd300, 16'd1, 16'd64};
    exp_k = '{16'd900, 16'd300, 16'd64, 16'd12, 16'd5, 16'd1, 16'd0};
    exp_p = '{8'd0, 8'd4, 8'd6, 8'd2, 8'd0, 8'd5, 8'd0};
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_op(1'b1, 1'b0, keys[i], 8'(i));
      n_checks++;
      if (ob_err !== 1'b0 || ob_rdy !== 1'b0 || ob_cnt != i + 1 || ob_lat > 9) begin
        n_fail++; $display("FAIL fill_enq%0d: err=%b rdy=%b cnt=%0d lat=%0d want 0/0/%0d/<=9", i, ob_err, ob_rdy, ob_cnt, ob_lat, i + 1);
      end
    end
    n_checks++;
    if (full !== 1'b1 || dat !== 16'd900 || !m_has(dat, pl)) begin
      n_fail++; $display("FAIL fill_root: full=%b data=%0d pl=%0d want full=1 data=900 pl 1 or 3", full, dat, pl);
    end
    run_op(1'b1, 1'b0, 16'd7, 8'd99);
    n_checks++;
    if (ob_err !== 1'b1 || cnt !== 3'd7 || dat !== 16'd900) begin
      n_fail++; $display("FAIL enq_full: err=%b cnt=%0d data=%0d want 1/7/900", ob_err, cnt, dat);
    end
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, 1'b1, 16'd0, 8'd0);
      n_checks++;
      if (dat !== exp_k[i] || cnt !== 3'(6 - i) || ob_lat > 9) begin
        n_fail++; $display("FAIL drain%0d: data=%0d cnt=%0d lat=%0d want %0d/%0d/<=9", i, dat, cnt, ob_lat, exp_k[i], 6 - i);
      end
      n_checks++;
      if (i == 0 ? !m_has(dat, pl) : (pl !== exp_p[i])) begin
        n_fail++; $display("FAIL drain_pl%0d: payload=%0d want %0d", i, pl, exp_p[i]);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || pl !== 8'd0) begin
      n_fail++; $display("FAIL drain_empty: empty=%b pl=%0d want 1/0", empty, pl);
    end
  endtask

  task automatic test_min_mode();
    sel = 1'b1;
    do_reset();
    run_op(1'b1, 1'b0, 16'd40, 8'd1);
    run_op(1'b1, 1'b0, 16'd7, 8'd2);
    run_op(1'b1, 1'b0, 16'd19, 8'd3);
    n_checks++;
    if (dat !== 16'd7 || pl !== 8'd2 || cnt !== 3'd3) begin
      n_fail++; $display("FAIL min_enq: data=%0d pl=%0d cnt=%0d want 7/2/3", dat, pl, cnt);
    end
    run_op(1'b1, 1'b1, 16'd50, 8'd4);
    n_checks++;
    if (dat !== 16'd19 || pl !== 8'd3 || cnt !== 3'd3) begin
      n_fail++; $display("FAIL min_rep: data=%0d pl=%0d cnt=%0d want 19/3/3", dat, pl, cnt);
    end
    run_op(1'b0, 1'b1, 16'd0, 8'd0);
    n_checks++;
    if (dat !== 16'd40 || pl !== 8'd1 || cnt !== 3'd2) begin
      n_fail++; $display("FAIL min_deq: data=%0d pl=%0d cnt=%0d want 40/1/2", dat, pl, cnt);
    end
    sel = 1'b0;
  endtask

  task automatic test_rep_edges();
    sel = 1'b0;
    do_reset();
    run_op(1'b1, 1'b1, 16'd3, 8'd33);
    n_checks++;
    if (ob_err !== 1'b0 || cnt !== 3'd1 || dat !== 16'd3 || pl !== 8'd33) begin
      n_fail++; $display("FAIL rep_empty: err=%b cnt=%0d data=%0d pl=%0d want 0/1/3/33", ob_err, cnt, dat, pl);
    end
    for (int i = 0; i < 6; i++) run_op(1'b1, 1'b0, 16'($urandom_range(0, 999)), 8'(i));
    run_op(1'b1, 1'b1, 16'd1000, 8'd77);
    n_checks++;
    if (ob_err !== 1'b0 || cnt !== 3'd7 || dat !== 16'd1000 || pl !== 8'd77 || ob_lat > 9) begin
      n_fail++; $display("FAIL rep_full: err=%b cnt=%0d data=%0d pl=%0d lat=%0d want 0/7/1000/77/<=9", ob_err, cnt, dat, pl, ob_lat);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0]  shown;
    logic [15:0] d0;
    int lat;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) run_op(1'b1, 1'b0, 16'($urandom_range(0, 999)), 8'(i + 10));
    shown = pl; d0 = dat;
    @(negedge CLK);
    rd = 1'b1;
    @(negedge CLK);
    rd = 1'b0;
    n_checks++;
    if (rdy !== 1'b0 || dat !== d0 || cnt !== 3'd4) begin
      n_fail++; $display("FAIL busy_hold: rdy=%b data=%0d cnt=%0d want 0/%0d/4", rdy, dat, cnt, d0);
    end
    lat = 1;
    while (!rdy && lat < 30) begin
      wrt = 1'b1; rd = 1'($urandom_range(0, 1)); din = 16'hFFFF; pin = 8'hEE;
      @(negedge CLK);
      lat++;
    end
    wrt = 1'b0; rd = 1'b0;
    m_remove_root(shown);
    n_checks++;
    if (lat > 9 || cnt !== 3'(mk.size()) || dat !== m_best() || !m_has(dat, pl)) begin
      n_fail++; $display("FAIL busy_ignore: lat=%0d cnt=%0d data=%0d pl=%0d want <=9/%0d/%0d", lat, cnt, dat, pl, mk.size(), m_best());
    end
    @(negedge CLK);
    n_checks++;
    if (rdy !== 1'b1 || err !== 1'b0 || cnt !== 3'(mk.size())) begin
      n_fail++; $display("FAIL busy_after: rdy=%b err=%b cnt=%0d want 1/0/%0d", rdy, err, cnt, mk.size());
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) run_op(1'b1, 1'b0, 16'(100 + 37 * i), 8'(i));
    @(negedge CLK);
    rd = 1'b1;
    @(negedge CLK);
    rd = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (rdy !== 1'b0) begin
      n_fail++; $display("FAIL mid_busy: rdy=%b want 0", rdy);
    end
    RSTn = 1'b0;
    #1;
    n_checks++;
    if (rdy !== 1'b1 || cnt !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || dat !== 16'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: rdy=%b cnt=%0d empty=%b full=%b data=%0d err=%b want 1/0/1/0/0/0", rdy, cnt, empty, full, dat, err);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    mk.delete(); mp.delete();
    @(negedge CLK);
    run_op(1'b0, 1'b1, 16'd0, 8'd0);
    n_checks++;
    if (ob_err !== 1'b1 || cnt !== 3'd0) begin
      n_fail++; $display("FAIL mid_after_deq: err=%b cnt=%0d want 1/0", ob_err, cnt);
    end
    run_op(1'b1, 1'b0, 16'd77, 8'd9);
    n_checks++;
    if (dat !== 16'd77 || pl !== 8'd9 || cnt !== 3'd1) begin
      n_fail++; $display("FAIL mid_after_enq: data=%0d pl=%0d cnt=%0d want 77/9/1", dat, pl, cnt);
    end
  endtask

  task automatic test_random(input logic s, input int n_ops);
    int t;
    bit exp_err;
    sel = s;
    do_reset();
    for (int n = 0; n < n_ops; n++) begin
      t = $urandom_range(0, 2);
      exp_err = (t == 0 && mk.size() == 7) || (t == 1 && mk.size() == 0);
      run_op(t != 1, t != 0, 16'($urandom_range(0, 1024)), 8'($urandom));
      n_checks++;
      if (ob_err !== exp_err || ob_rdy !== exp_err || ob_lat > 9) begin
        n_fail++; $display("FAIL rnd_hs s%0d op%0d type%0d: err=%b rdy=%b lat=%0d want err=rdy=%b lat<=9", s, n, t, ob_err, ob_rdy, ob_lat, exp_err);
      end
      n_checks++;
      if (cnt !== 3'(mk.size()) || empty !== (mk.size() == 0) || full !== (mk.size() == 7)) begin
        n_fail++; $display("FAIL rnd_cnt s%0d op%0d: cnt=%0d empty=%b full=%b want %0d", s, n, cnt, empty, full, mk.size());
      end
      n_checks++;
      if (mk.size() == 0 ? (dat !== 16'd0 || pl !== 8'd0) : (dat !== m_best() || !m_has(dat, pl))) begin
        n_fail++; $display("FAIL rnd_root s%0d op%0d: data=%0d pl=%0d want %0d", s, n, dat, pl, m_best());
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; wrt = 1'b0; rd = 1'b0; din = '0; pin = '0; sel = 1'b0;
    test_reset();
    test_fill_drain();
    test_min_mode();
    test_rep_edges();
    test_busy_ignore();
    test_reset_mid();
    test_random(1'b0, 1000);
    test_random(1'b1, 300);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
